// File: rtl/ysyx_mc_sequencer_if.sv
// Fetch and memory handshake bundle between the multi-cycle sequencer and the IFU/LSU.
// A request transfers in the cycle where valid and ready are both high; responses are one-cycle valid pulses.
interface ysyx_mc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic [WIDTH-1:0] ifu_addr;
    logic             ifu_rsp_valid;
    logic [31:0]      ifu_rsp_data;
    logic             ifu_rsp_err;
    logic             lsu_req_valid;
    logic             lsu_req_ready;
    logic             lsu_rsp_valid;
    logic             lsu_rsp_err;

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
    );

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
    );
endinterface

// File: rtl/ysyx_mc_sequencer.sv
// Multi-cycle core sequencer: owns PC and IR, steps fetch/exec/memory/commit over IFU/LSU handshakes,
// qualifies register/CSR writes, raises precise traps on bus faults or timeouts, counts retirements.
module ysyx_mc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int               TIMEOUT   = 255,
    parameter int               CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_mc_sequencer_if.master  bus,
    output logic [31:0]          inst,
    output logic [WIDTH-1:0]     pc,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_illegal,
    input  logic                 rd_we,
    input  logic                 csr_we,
    input  logic [WIDTH-1:0]     next_pc,
    input  logic [WIDTH-1:0]     mtvec,
    output logic                 rf_we_en,
    output logic                 csr_we_en,
    output logic                 trap_valid,
    output logic [3:0]           trap_cause,
    output logic [WIDTH-1:0]     trap_pc,
    output logic                 retire_valid,
    output logic [CNT_WIDTH-1:0] retire_count,
    output logic [2:0]           dbg_state
);
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TO_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MREQ  = 3'd3,
        S_MWAIT = 3'd4
    } state_t;

    state_t           state, state_n;
    logic             commit, trap_now, latch_inst, ifu_req, lsu_req;
    logic             timed_out, mem_is_store;
    logic [3:0]       cause_now, cause_q, mem_cause;
    logic [WIDTH-1:0] trap_pc_q;
    logic [WCW-1:0]   wait_cnt;

    assign mem_cause = mem_is_store ? 4'd7 : 4'd5;
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

    // A handshake seen in the same cycle as the timeout wins over the timeout.
    always_comb begin
        state_n    = state;
        commit     = 1'b0;
        trap_now   = 1'b0;
        cause_now  = 4'd0;
        latch_inst = 1'b0;
        ifu_req    = 1'b0;
        lsu_req    = 1'b0;
        case (state)
            S_FETCH: begin
                ifu_req = rst_n;
                if (bus.ifu_req_ready) state_n = S_IWAIT;
                else if (timed_out) begin trap_now = 1'b1; cause_now = 4'd1; end
            end
            S_IWAIT: begin
                if (bus.ifu_rsp_valid) begin
                    if (bus.ifu_rsp_err) begin trap_now = 1'b1; cause_now = 4'd1; end
                    else begin latch_inst = 1'b1; state_n = S_EXEC; end
                end else if (timed_out) begin trap_now = 1'b1; cause_now = 4'd1; end
            end
            S_EXEC: begin
                if (dec_illegal) begin trap_now = 1'b1; cause_now = 4'd2; end
                else if (dec_is_load || dec_is_store) state_n = S_MREQ;
                else commit = 1'b1;
            end
            S_MREQ: begin
                lsu_req = 1'b1;
                if (bus.lsu_req_ready) state_n = S_MWAIT;
                else if (timed_out) begin trap_now = 1'b1; cause_now = mem_cause; end
            end
            S_MWAIT: begin
                if (bus.lsu_rsp_valid) begin
                    if (bus.lsu_rsp_err) begin trap_now = 1'b1; cause_now = mem_cause; end
                    else commit = 1'b1;
                end else if (timed_out) begin trap_now = 1'b1; cause_now = mem_cause; end
            end
            default: state_n = S_FETCH;
        endcase
        if (commit || trap_now) state_n = S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            inst         <= 32'h0000_0013;
            retire_count <= '0;
            cause_q      <= 4'd0;
            trap_pc_q    <= '0;
            mem_is_store <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (latch_inst) inst <= bus.ifu_rsp_data;
            if (state == S_EXEC) mem_is_store <= dec_is_store;
            if (commit) begin
                pc           <= next_pc;
                retire_count <= retire_count + 1'b1;
            end else if (trap_now) begin
                pc        <= mtvec;
                cause_q   <= cause_now;
                trap_pc_q <= pc;
            end
            // Every entry into a state (including a trap back into FETCH) restarts the wait window.
            if (trap_now || (state_n != state)) wait_cnt <= '0;
            else if (wait_cnt != '1)            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.ifu_req_valid = ifu_req;
    assign bus.ifu_addr      = pc;
    assign bus.lsu_req_valid = lsu_req;
    assign rf_we_en          = commit & rd_we;
    assign csr_we_en         = commit & csr_we;
    assign retire_valid      = commit;
    assign trap_valid        = trap_now;
    assign trap_cause        = trap_now ? cause_now : cause_q;
    assign trap_pc           = trap_now ? pc : trap_pc_q;
    assign dbg_state         = state;
endmodule

// File: tb/tb_ysyx_mc_sequencer.sv
// Directed bench for ysyx_mc_sequencer: ALU/CSR/load/store flows, traps, timeouts, stray responses, counter wrap.
module tb_ysyx_mc_sequencer;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [2:0] S_FETCH = 3'd0, S_IWAIT = 3'd1, S_EXEC = 3'd2, S_MREQ = 3'd3, S_MWAIT = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ysyx_mc_sequencer_if #(.WIDTH(32)) bus();
    logic [31:0] inst, pc, next_pc, mtvec, trap_pc;
    logic dec_is_load, dec_is_store, dec_illegal, rd_we, csr_we;
    logic rf_we_en, csr_we_en, trap_valid, retire_valid;
    logic [3:0] trap_cause, retire_count;
    logic [2:0] dbg_state;

    ysyx_mc_sequencer #(.WIDTH(32), .RESET_PC(RPC), .TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst), .pc(pc),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_illegal(dec_illegal),
        .rd_we(rd_we), .csr_we(csr_we), .next_pc(next_pc), .mtvec(mtvec),
        .rf_we_en(rf_we_en), .csr_we_en(csr_we_en), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .retire_valid(retire_valid), .retire_count(retire_count), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Observations collected by the driver over one instruction.
    int o_cycles, o_rf, o_csr, o_retire, o_trap, o_both, o_lsu_req;
    bit o_done;
    logic [3:0] o_cause;
    logic [31:0] o_trap_pc, o_addr;

    task automatic zero_inputs();
        bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0; bus.ifu_rsp_err = 1'b0;
        bus.ifu_rsp_data = 32'h0; bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_err = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_illegal = 1'b0;
    endtask

    // Called just after a rising edge with the DUT in FETCH; returns just after the edge that ends the instruction.
    task automatic run_insn(input logic [31:0] insn, input logic ld, input logic st, input logic ill,
                            input int ifu_rdy_dly, input int ifu_rsp_dly, input logic ifu_err,
                            input int lsu_rdy_dly, input int lsu_rsp_dly, input logic lsu_err,
                            input logic lsu_never);
        int sc;
        logic [2:0] prev;
        bit first;
        o_cycles = 0; o_rf = 0; o_csr = 0; o_retire = 0; o_trap = 0; o_both = 0; o_lsu_req = 0;
        o_done = 1'b0; o_cause = 4'hx; o_trap_pc = 32'hx; o_addr = 32'hx;
        first = 1'b1; sc = 0; prev = 3'd0;
        dec_is_load = ld; dec_is_store = st; dec_illegal = ill; bus.ifu_rsp_data = insn;
        while (!o_done && o_cycles < 40) begin
            if (first || dbg_state != prev) sc = 0; else sc++;
            first = 1'b0; prev = dbg_state;
            bus.ifu_req_ready = (dbg_state == S_FETCH) && (sc >= ifu_rdy_dly);
            bus.ifu_rsp_valid = (dbg_state == S_IWAIT) && (sc >= ifu_rsp_dly);
            bus.ifu_rsp_err   = ifu_err;
            bus.lsu_req_ready = (dbg_state == S_MREQ) && (sc >= lsu_rdy_dly);
            bus.lsu_rsp_valid = (dbg_state == S_MWAIT) && !lsu_never && (sc >= lsu_rsp_dly);
            bus.lsu_rsp_err   = lsu_err;
            #3;
            o_cycles++;
            if (o_cycles == 1 && bus.ifu_req_valid) o_addr = bus.ifu_addr;
            if (rf_we_en) o_rf++;
            if (csr_we_en) o_csr++;
            if (bus.lsu_req_valid) o_lsu_req++;
            if (retire_valid) o_retire++;
            if (retire_valid && trap_valid) o_both++;
            if (trap_valid) begin o_trap++; o_cause = trap_cause; o_trap_pc = trap_pc; end
            if (retire_valid || trap_valid) o_done = 1'b1;
            @(posedge clk); #1;
        end
        zero_inputs();
    endtask

    task automatic reset_assert();
        zero_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_assert();
        checks++; if (pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
        checks++; if (inst !== 32'h13) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, 32'h13); end
        checks++; if (retire_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", retire_count); end
        checks++; if (dbg_state !== S_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_FETCH); end
        checks++; if ({bus.ifu_req_valid, bus.lsu_req_valid, rf_we_en, csr_we_en, trap_valid, retire_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000000",
                {bus.ifu_req_valid, bus.lsu_req_valid, rf_we_en, csr_we_en, trap_valid, retire_valid}); end
        checks++; if (trap_cause !== 4'd0 || trap_pc !== 32'h0) begin failures++;
            $display("FAIL reset_trap_regs got=%0d/%h exp=0/0", trap_cause, trap_pc); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.ifu_req_valid !== 1'b1) begin failures++; $display("FAIL release_fetch got=%b exp=1", bus.ifu_req_valid); end
    endtask

    task automatic test_alu();
        rd_we = 1'b1; csr_we = 1'b0; next_pc = RPC + 32'd4;
        run_insn(32'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o_addr !== RPC) begin failures++; $display("FAIL alu_addr got=%h exp=%h", o_addr, RPC); end
        checks++; if (o_cycles !== 3) begin failures++; $display("FAIL alu_latency got=%0d exp=3", o_cycles); end
        checks++; if (o_retire !== 1 || o_rf !== 1 || o_csr !== 0 || o_trap !== 0) begin failures++;
            $display("FAIL alu_strobes got=ret%0d rf%0d csr%0d trap%0d exp=1 1 0 0", o_retire, o_rf, o_csr, o_trap); end
        checks++; if (pc !== 32'h8000_0004) begin failures++; $display("FAIL alu_pc got=%h exp=80000004", pc); end
        checks++; if (inst !== 32'h0050_0093) begin failures++; $display("FAIL alu_inst got=%h exp=00500093", inst); end
        checks++; if (retire_count !== 4'd1) begin failures++; $display("FAIL alu_count got=%0d exp=1", retire_count); end
    endtask

    task automatic test_csr();
        rd_we = 1'b0; csr_we = 1'b1; next_pc = 32'h8000_0008;
        run_insn(32'h3057_1073, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        checks++; if (o_addr !== 32'h8000_0004) begin failures++; $display("FAIL csr_addr got=%h exp=80000004", o_addr); end
        checks++; if (o_cycles !== 6) begin failures++; $display("FAIL csr_latency got=%0d exp=6", o_cycles); end
        checks++; if (o_csr !== 1 || o_rf !== 0) begin failures++; $display("FAIL csr_strobes got=csr%0d rf%0d exp=1 0", o_csr, o_rf); end
        checks++; if (pc !== 32'h8000_0008 || retire_count !== 4'd2) begin failures++;
            $display("FAIL csr_commit got=%h/%0d exp=80000008/2", pc, retire_count); end
    endtask

    task automatic test_load();
        rd_we = 1'b1; csr_we = 1'b0; next_pc = 32'h8000_000c;
        run_insn(32'h0000_a103, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0);
        checks++; if (o_lsu_req !== 3) begin failures++; $display("FAIL load_req_hold got=%0d exp=3", o_lsu_req); end
        checks++; if (o_cycles !== 9) begin failures++; $display("FAIL load_latency got=%0d exp=9", o_cycles); end
        checks++; if (o_rf !== 1 || o_retire !== 1) begin failures++; $display("FAIL load_commit got=rf%0d ret%0d exp=1 1", o_rf, o_retire); end
        checks++; if (pc !== 32'h8000_000c || retire_count !== 4'd3) begin failures++;
            $display("FAIL load_state got=%h/%0d exp=8000000c/3", pc, retire_count); end
        rd_we = 1'b1; next_pc = 32'h8000_0010;
    endtask

    task automatic test_illegal();
        mtvec = 32'h8000_1000;
        run_insn(32'hffff_ffff, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o_trap !== 1 || o_cause !== 4'd2) begin failures++; $display("FAIL ill_trap got=n%0d c%0d exp=1 2", o_trap, o_cause); end
        checks++; if (o_trap_pc !== 32'h8000_000c) begin failures++; $display("FAIL ill_trap_pc got=%h exp=8000000c", o_trap_pc); end
        checks++; if (o_rf !== 0 || o_retire !== 0 || o_lsu_req !== 0 || o_cycles !== 3) begin failures++;
            $display("FAIL ill_side got=rf%0d ret%0d lsu%0d cyc%0d exp=0 0 0 3", o_rf, o_retire, o_lsu_req, o_cycles); end
        checks++; if (pc !== 32'h8000_1000 || retire_count !== 4'd3) begin failures++;
            $display("FAIL ill_state got=%h/%0d exp=80001000/3", pc, retire_count); end
        checks++; if (trap_cause !== 4'd2 || trap_pc !== 32'h8000_000c) begin failures++;
            $display("FAIL ill_hold got=%0d/%h exp=2/8000000c", trap_cause, trap_pc); end
    endtask

    task automatic test_mem_faults();
        mtvec = 32'h8000_2000;
        run_insn(32'h0020_a023, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (o_cause !== 4'd7 || o_cycles !== 5 || o_trap_pc !== 32'h8000_1000) begin failures++;
            $display("FAIL st_err got=c%0d cyc%0d pc%h exp=7 5 80001000", o_cause, o_cycles, o_trap_pc); end
        checks++; if (pc !== 32'h8000_2000 || o_rf !== 0 || o_retire !== 0) begin failures++;
            $display("FAIL st_err_state got=%h rf%0d ret%0d exp=80002000 0 0", pc, o_rf, o_retire); end
        mtvec = 32'h8000_3000;
        run_insn(32'h0020_a023, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL st_to_bound got=%0d exp=1", o_done); end
        checks++; if (o_cause !== 4'd7 || o_cycles !== 8) begin failures++;
            $display("FAIL st_timeout got=c%0d cyc%0d exp=7 8", o_cause, o_cycles); end
        checks++; if (pc !== 32'h8000_3000 || o_trap_pc !== 32'h8000_2000) begin failures++;
            $display("FAIL st_to_pc got=%h/%h exp=80003000/80002000", pc, o_trap_pc); end
        mtvec = 32'h8000_4000;
        run_insn(32'h0000_a183, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++; if (o_cause !== 4'd5 || o_cycles !== 6 || o_rf !== 0) begin failures++;
            $display("FAIL ld_err got=c%0d cyc%0d rf%0d exp=5 6 0", o_cause, o_cycles, o_rf); end
        checks++; if (retire_count !== 4'd3 || pc !== 32'h8000_4000) begin failures++;
            $display("FAIL ld_err_state got=%0d/%h exp=3/80004000", retire_count, pc); end
    endtask

    task automatic test_ifu_faults();
        mtvec = 32'h8000_5000;
        run_insn(32'h1234_5678, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (o_cause !== 4'd1 || o_cycles !== 2 || o_trap_pc !== 32'h8000_4000) begin failures++;
            $display("FAIL ifu_err got=c%0d cyc%0d pc%h exp=1 2 80004000", o_cause, o_cycles, o_trap_pc); end
        checks++; if (inst !== 32'h0000_a183) begin failures++; $display("FAIL ifu_err_inst got=%h exp=0000a183", inst); end
        mtvec = 32'h8000_6000;
        run_insn(32'h0, 0, 0, 0, 99, 0, 0, 0, 0, 0, 0);
        checks++; if (o_cause !== 4'd1 || o_cycles !== 4 || pc !== 32'h8000_6000) begin failures++;
            $display("FAIL fetch_timeout got=c%0d cyc%0d pc%h exp=1 4 80006000", o_cause, o_cycles, pc); end
    endtask

    task automatic test_stray_reset();
        bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_data = 32'hdead_beef; bus.lsu_rsp_valid = 1'b1;
        @(posedge clk); #1;
        bus.ifu_rsp_valid = 1'b0; bus.lsu_rsp_valid = 1'b0; bus.ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.ifu_req_ready = 1'b0;
        checks++; if (dbg_state !== S_IWAIT) begin failures++; $display("FAIL stray_state got=%0d exp=%0d", dbg_state, S_IWAIT); end
        checks++; if (inst !== 32'h0000_a183) begin failures++; $display("FAIL stray_inst got=%h exp=0000a183", inst); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== RPC || dbg_state !== S_FETCH || retire_count !== 4'd0) begin failures++;
            $display("FAIL mid_reset got=%h/%0d/%0d exp=%h/0/0", pc, dbg_state, retire_count, RPC); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_we = 1'b1; csr_we = 1'b0; next_pc = RPC + 32'd4;
        run_insn(32'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o_addr !== RPC || o_cycles !== 3 || retire_count !== 4'd1) begin failures++;
            $display("FAIL post_reset got=%h cyc%0d cnt%0d exp=%h 3 1", o_addr, o_cycles, retire_count, RPC); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        int bad_lat, both;
        reset_assert();
        rst_n = 1'b1;
        exp_pc = RPC; bad_lat = 0; both = 0;
        rd_we = 1'b1; csr_we = 1'b0;
        for (int i = 0; i < 17; i++) begin
            next_pc = exp_pc + 32'd4;
            run_insn(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (o_cycles != 3 || o_addr !== exp_pc) bad_lat++;
            both += o_both;
            exp_pc = exp_pc + 32'd4;
        end
        checks++; if (bad_lat !== 0) begin failures++; $display("FAIL b2b_latency got=%0d bad exp=0", bad_lat); end
        checks++; if (both !== 0) begin failures++; $display("FAIL b2b_exclusive got=%0d exp=0", both); end
        checks++; if (retire_count !== 4'd1) begin failures++; $display("FAIL count_wrap got=%0d exp=1", retire_count); end
        checks++; if (pc !== RPC + 32'd68) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", pc, RPC + 32'd68); end
    endtask

    initial begin
        rd_we = 1'b0; csr_we = 1'b0; next_pc = 32'h0; mtvec = 32'h0;
        zero_inputs();
        test_reset();
        test_alu();
        test_csr();
        test_load();
        test_illegal();
        test_mem_faults();
        test_ifu_faults();
        test_stray_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
